// File: rtl/traffic_fsm.sv
//==============================================================================
// traffic_fsm : intersection controller with a one-second prescaler, per-state
//               countdown, programmable intervals and a latched walk request.
// Revision    : 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module traffic_fsm #(
   parameter int unsigned TICK_DIV = 100000000,
   parameter int unsigned BASE_DEF = 6,
   parameter int unsigned EXT_DEF  = 3,
   parameter int unsigned YEL_DEF  = 2
) (
   input  logic       clk,
   input  logic       Reset,
   input  logic       Sensor_Sync,
   input  logic       WR_Sync,
   input  logic       Prog_Sync,
   input  logic [1:0] Time_Sel,
   input  logic [3:0] Time_Value,
   output logic [2:0] Main_Lights,
   output logic [2:0] Side_Lights,
   output logic       Walk_Lamp
);

   localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] C_TICK_LAST = PW'(TICK_DIV - 1);
   localparam logic [3:0] C_BASE_DEF = 4'(BASE_DEF);
   localparam logic [3:0] C_EXT_DEF  = 4'(EXT_DEF);
   localparam logic [3:0] C_YEL_DEF  = 4'(YEL_DEF);

   typedef enum logic [2:0] {
      MG_BASE = 3'd0,
      MG_EXT  = 3'd1,
      MY      = 3'd2,
      WALK    = 3'd3,
      SG      = 3'd4,
      SG_EXT  = 3'd5,
      SY      = 3'd6
   } state_t;

   state_t        state;
   state_t        nxt;
   logic [PW-1:0] presc;
   logic [3:0]    cnt;
   logic [3:0]    base_int;
   logic [3:0]    ext_int;
   logic [3:0]    yel_int;
   logic          walk_pend;
   logic          tick;

   // A programmed interval of zero behaves as one second.
   function automatic logic [3:0] eff(input logic [3:0] v);
      return (v == 4'd0) ? 4'd1 : v;
   endfunction

   function automatic logic [3:0] interval_of(input state_t s, input logic [3:0] b,
                                              input logic [3:0] e, input logic [3:0] y);
      case (s)
         MG_BASE, SG:        return eff(b);
         MG_EXT, WALK, SG_EXT: return eff(e);
         default:            return eff(y);
      endcase
   endfunction

   // {Main R,Y,G, Side R,Y,G, Walk}
   function automatic logic [6:0] lamps(input state_t s);
      case (s)
         MG_BASE, MG_EXT: return 7'b001_100_0;
         MY:              return 7'b010_100_0;
         WALK:            return 7'b100_100_1;
         SG, SG_EXT:      return 7'b100_001_0;
         SY:              return 7'b100_010_0;
         default:         return 7'b001_100_0;
      endcase
   endfunction

   assign tick = (presc == C_TICK_LAST);

   // Transition target, only used on the final tick of a state.
   always_comb begin
      nxt = MG_BASE;
      case (state)
         MG_BASE: nxt = Sensor_Sync ? MY : MG_EXT;
         MG_EXT:  nxt = MY;
         MY:      nxt = (walk_pend || WR_Sync) ? WALK : SG;
         WALK:    nxt = SG;
         SG:      nxt = Sensor_Sync ? SG_EXT : SY;
         SG_EXT:  nxt = SY;
         SY:      nxt = MG_BASE;
         default: nxt = MG_BASE;
      endcase
   end

   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         state       <= MG_BASE;
         {Main_Lights, Side_Lights, Walk_Lamp} <= 7'b001_100_0;
         base_int    <= C_BASE_DEF;
         ext_int     <= C_EXT_DEF;
         yel_int     <= C_YEL_DEF;
         walk_pend   <= 1'b0;
         presc       <= '0;
         cnt         <= eff(C_BASE_DEF);
      end else begin
         if (WR_Sync && (state != WALK))
            walk_pend <= 1'b1;

         if (Prog_Sync) begin
            case (Time_Sel)
               2'b00:   base_int <= Time_Value;
               2'b01:   ext_int  <= Time_Value;
               2'b10:   yel_int  <= Time_Value;
               default: ;
            endcase
            state <= MG_BASE;
            {Main_Lights, Side_Lights, Walk_Lamp} <= lamps(MG_BASE);
            presc <= '0;
            cnt   <= (Time_Sel == 2'b00) ? eff(Time_Value) : eff(base_int);
         end else if (tick) begin
            presc <= '0;
            if (cnt <= 4'd1) begin
               state <= nxt;
               {Main_Lights, Side_Lights, Walk_Lamp} <= lamps(nxt);
               cnt <= interval_of(nxt, base_int, ext_int, yel_int);
               // Entering WALK consumes the request, overriding a same-cycle set.
               if (nxt == WALK)
                  walk_pend <= 1'b0;
            end else begin
               cnt <= cnt - 4'd1;
            end
         end else begin
            presc <= presc + PW'(1);
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_traffic_fsm.sv
//==============================================================================
// tb_traffic_fsm : vector table, hand sequences and random stimulus against a
//                  cycle-count reference model of the intersection controller.
// Revision       : 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_traffic_fsm;

   localparam int TD = 4;

   logic       clk = 1'b0;
   logic       Reset;
   logic       Sensor_Sync;
   logic       WR_Sync;
   logic       Prog_Sync;
   logic [1:0] Time_Sel;
   logic [3:0] Time_Value;
   logic [2:0] Main_Lights;
   logic [2:0] Side_Lights;
   logic       Walk_Lamp;

   int checks   = 0;
   int failures = 0;

   traffic_fsm #(.TICK_DIV(TD), .BASE_DEF(6), .EXT_DEF(3), .YEL_DEF(2)) dut (
      .clk         (clk),
      .Reset       (Reset),
      .Sensor_Sync (Sensor_Sync),
      .WR_Sync     (WR_Sync),
      .Prog_Sync   (Prog_Sync),
      .Time_Sel    (Time_Sel),
      .Time_Value  (Time_Value),
      .Main_Lights (Main_Lights),
      .Side_Lights (Side_Lights),
      .Walk_Lamp   (Walk_Lamp)
   );

   always #5 clk = ~clk;

   // Reference model: phase name plus cycles remaining in that phase.
   localparam int P_MGB = 0, P_MGE = 1, P_MY = 2, P_WALK = 3, P_SG = 4, P_SGE = 5, P_SY = 6;
   int       m_phase;
   int       m_rem;
   bit       m_pend;
   bit [3:0] m_base, m_ext, m_yel;

   function automatic int secs(input bit [3:0] v);
      return (v == 0) ? 1 : int'(v);
   endfunction

   function automatic int phase_cycles(input int p);
      if (p == P_MGB || p == P_SG) return secs(m_base) * TD;
      if (p == P_MY || p == P_SY)  return secs(m_yel) * TD;
      return secs(m_ext) * TD;
   endfunction

   function automatic bit [6:0] expect_out(input int p);
      case (p)
         P_MGB, P_MGE: return 7'b001_100_0;
         P_MY:         return 7'b010_100_0;
         P_WALK:       return 7'b100_100_1;
         P_SG, P_SGE:  return 7'b100_001_0;
         default:      return 7'b100_010_0;
      endcase
   endfunction

   task automatic model_reset();
      m_base = 4'd6; m_ext = 4'd3; m_yel = 4'd2;
      m_pend = 0;
      m_phase = P_MGB;
      m_rem = phase_cycles(P_MGB);
   endtask

   task automatic model_step();
      int nx;
      if (WR_Sync && m_phase != P_WALK) m_pend = 1;
      if (Prog_Sync) begin
         if (Time_Sel == 2'b00) m_base = Time_Value;
         if (Time_Sel == 2'b01) m_ext  = Time_Value;
         if (Time_Sel == 2'b10) m_yel  = Time_Value;
         m_phase = P_MGB;
         m_rem = phase_cycles(P_MGB);
      end else if (m_rem == 1) begin
         case (m_phase)
            P_MGB:   nx = Sensor_Sync ? P_MY : P_MGE;
            P_MGE:   nx = P_MY;
            P_MY:    nx = m_pend ? P_WALK : P_SG;
            P_WALK:  nx = P_SG;
            P_SG:    nx = Sensor_Sync ? P_SGE : P_SY;
            P_SGE:   nx = P_SY;
            default: nx = P_MGB;
         endcase
         if (nx == P_WALK) m_pend = 0;
         m_phase = nx;
         m_rem = phase_cycles(nx);
      end else begin
         m_rem--;
      end
   endtask

   task automatic cmp(input string name, input bit [6:0] act, input bit [6:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s at %0t: lamps actual=%b required=%b", name, $time, act, req);
      end
   endtask

   function automatic bit [6:0] outs();
      return {Main_Lights, Side_Lights, Walk_Lamp};
   endfunction

   task automatic step();
      @(posedge clk);
      if (Reset) model_reset();
      else model_step();
      #1;
      cmp("model", outs(), expect_out(m_phase));
   endtask

   typedef struct {
      bit       prog;
      bit [1:0] sel;
      bit [3:0] val;
      bit       sensor;
      bit       wr;
      int       cycles;
      bit [6:0] exp_out;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input bit prog, input bit [1:0] sel, input bit [3:0] val,
                               input bit sensor, input bit wr, input int cycles,
                               input bit [2:0] m, input bit [2:0] s, input bit w);
      vec_t v;
      v.prog = prog; v.sel = sel; v.val = val; v.sensor = sensor; v.wr = wr;
      v.cycles = cycles; v.exp_out = {m, s, w};
      return v;
   endfunction

   initial begin
      Reset = 1'b1; Sensor_Sync = 0; WR_Sync = 0; Prog_Sync = 0;
      Time_Sel = 2'b11; Time_Value = 4'd0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      cmp("reset_state", outs(), 7'b001_100_0);
      Reset = 1'b0;

      // Free run, no sensor
      tbl.push_back(mk(0, 3, 0, 0, 0, 35, 3'b001, 3'b100, 0));
      tbl.push_back(mk(0, 3, 0, 0, 0,  1, 3'b010, 3'b100, 0));
      tbl.push_back(mk(0, 3, 0, 0, 0,  7, 3'b010, 3'b100, 0));
      tbl.push_back(mk(0, 3, 0, 0, 0,  1, 3'b100, 3'b001, 0));
      tbl.push_back(mk(0, 3, 0, 0, 0, 23, 3'b100, 3'b001, 0));
      tbl.push_back(mk(0, 3, 0, 0, 0,  1, 3'b100, 3'b010, 0));
      tbl.push_back(mk(0, 3, 0, 0, 0,  7, 3'b100, 3'b010, 0));
      tbl.push_back(mk(0, 3, 0, 0, 0,  1, 3'b001, 3'b100, 0));
      // Sensor held high
      tbl.push_back(mk(0, 3, 0, 1, 0, 23, 3'b001, 3'b100, 0));
      tbl.push_back(mk(0, 3, 0, 1, 0,  1, 3'b010, 3'b100, 0));
      tbl.push_back(mk(0, 3, 0, 1, 0,  7, 3'b010, 3'b100, 0));
      tbl.push_back(mk(0, 3, 0, 1, 0,  1, 3'b100, 3'b001, 0));
      tbl.push_back(mk(0, 3, 0, 1, 0, 35, 3'b100, 3'b001, 0));
      tbl.push_back(mk(0, 3, 0, 1, 0,  1, 3'b100, 3'b010, 0));
      tbl.push_back(mk(0, 3, 0, 1, 0,  7, 3'b100, 3'b010, 0));
      tbl.push_back(mk(0, 3, 0, 1, 0,  1, 3'b001, 3'b100, 0));
      // Walk request pulse during MG_EXT, then a cycle that skips WALK
      tbl.push_back(mk(0, 3, 0, 0, 0, 24, 3'b001, 3'b100, 0));
      tbl.push_back(mk(0, 3, 0, 0, 1,  1, 3'b001, 3'b100, 0));
      tbl.push_back(mk(0, 3, 0, 0, 0, 11, 3'b010, 3'b100, 0));
      tbl.push_back(mk(0, 3, 0, 0, 0,  7, 3'b010, 3'b100, 0));
      tbl.push_back(mk(0, 3, 0, 0, 0,  1, 3'b100, 3'b100, 1));
      tbl.push_back(mk(0, 3, 0, 0, 0, 11, 3'b100, 3'b100, 1));
      tbl.push_back(mk(0, 3, 0, 0, 0,  1, 3'b100, 3'b001, 0));
      tbl.push_back(mk(0, 3, 0, 0, 0, 23, 3'b100, 3'b001, 0));
      tbl.push_back(mk(0, 3, 0, 0, 0,  1, 3'b100, 3'b010, 0));
      tbl.push_back(mk(0, 3, 0, 0, 0,  7, 3'b100, 3'b010, 0));
      tbl.push_back(mk(0, 3, 0, 0, 0,  1, 3'b001, 3'b100, 0));
      tbl.push_back(mk(0, 3, 0, 0, 0, 35, 3'b001, 3'b100, 0));
      tbl.push_back(mk(0, 3, 0, 0, 0,  1, 3'b010, 3'b100, 0));
      tbl.push_back(mk(0, 3, 0, 0, 0,  7, 3'b010, 3'b100, 0));
      tbl.push_back(mk(0, 3, 0, 0, 0,  1, 3'b100, 3'b001, 0));
      // Reprogram YEL=5 during SG, then Time_Sel=11 restart
      tbl.push_back(mk(0, 3, 0, 0, 0,  5, 3'b100, 3'b001, 0));
      tbl.push_back(mk(1, 2, 5, 0, 0,  1, 3'b001, 3'b100, 0));
      tbl.push_back(mk(0, 3, 0, 0, 0, 35, 3'b001, 3'b100, 0));
      tbl.push_back(mk(0, 3, 0, 0, 0,  1, 3'b010, 3'b100, 0));
      tbl.push_back(mk(0, 3, 0, 0, 0, 19, 3'b010, 3'b100, 0));
      tbl.push_back(mk(0, 3, 0, 0, 0,  1, 3'b100, 3'b001, 0));
      tbl.push_back(mk(1, 3, 9, 0, 0,  1, 3'b001, 3'b100, 0));
      tbl.push_back(mk(0, 3, 0, 0, 0, 35, 3'b001, 3'b100, 0));
      tbl.push_back(mk(0, 3, 0, 0, 0,  1, 3'b010, 3'b100, 0));
      tbl.push_back(mk(0, 3, 0, 0, 0, 19, 3'b010, 3'b100, 0));
      tbl.push_back(mk(0, 3, 0, 0, 0,  1, 3'b100, 3'b001, 0));
      // Zero BASE interval lasts one second
      tbl.push_back(mk(1, 0, 0, 0, 0,  1, 3'b001, 3'b100, 0));
      tbl.push_back(mk(0, 3, 0, 0, 0, 15, 3'b001, 3'b100, 0));
      tbl.push_back(mk(0, 3, 0, 0, 0,  1, 3'b010, 3'b100, 0));

      foreach (tbl[i]) begin
         Prog_Sync = tbl[i].prog; Time_Sel = tbl[i].sel; Time_Value = tbl[i].val;
         Sensor_Sync = tbl[i].sensor; WR_Sync = tbl[i].wr;
         for (int k = 0; k < tbl[i].cycles; k++) step();
         cmp($sformatf("vec%0d", i), outs(), tbl[i].exp_out);
      end
      Prog_Sync = 0; WR_Sync = 0; Sensor_Sync = 0; Time_Sel = 2'b11;

      // Async reset mid-WALK, then confirm the pending request was dropped
      WR_Sync = 1; step(); WR_Sync = 0;
      for (int i = 0; i < 200 && !Walk_Lamp; i++) step();
      cmp("walk_reached", {6'b0, Walk_Lamp}, 7'd1);
      repeat (3) step();
      #2;
      Reset = 1'b1;
      #1;
      cmp("async_reset", outs(), 7'b001_100_0);
      model_reset();
      step();
      Reset = 1'b0;
      repeat (44) step();
      cmp("pend_cleared", outs(), 7'b100_001_0);

      // Randomized run against the model
      for (int n = 0; n < 4000; n++) begin
         Sensor_Sync = 1'($urandom_range(0, 1));
         WR_Sync     = ($urandom_range(0, 15) == 0);
         Prog_Sync   = ($urandom_range(0, 199) == 0);
         Time_Sel    = 2'($urandom_range(0, 3));
         Time_Value  = 4'($urandom_range(0, 4));
         if ($urandom_range(0, 999) == 0) begin
            Reset = 1'b1;
            #1;
            cmp("rand_async_reset", outs(), 7'b001_100_0);
            model_reset();
            step();
            Reset = 1'b0;
         end
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
